// File: rtl/adc_multi_avg.sv
// Multi-channel averaging ADC reader: CNV/BUSY handshake, SPI frame capture, 2^log2_n frame averaging.
// Optional feature macro: ADC_MULTI_AVG_SIGNED_EN (two's complement samples and results).
module adc_multi_avg #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CH_WIDTH     = 18,
  parameter int unsigned OUT_WIDTH    = 24,
  parameter int unsigned MAX_LOG2_N   = 10,
  parameter int unsigned ACC_WIDTH    = 28,
  parameter int unsigned SCK_DIV      = 2,
  parameter int unsigned CNV_CYCLES   = 2,
  parameter int unsigned BUSY_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_cycle,
  input  logic                        sample_adc,
  input  logic [3:0]                  log2_n,
  output logic                        cnv,
  input  logic                        adc_busy,
  output logic                        sck,
  input  logic                        miso,
  output logic [NUM_CH*OUT_WIDTH-1:0] data_out,
  output logic                        complete,
  output logic                        error,
  output logic                        overrun,
  output logic                        active
);

  localparam int unsigned FRAME_W = NUM_CH * CH_WIDTH;
  localparam int unsigned BC_W    = $clog2(FRAME_W + 1);
  localparam int unsigned FC_W    = MAX_LOG2_N + 1;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE, WAIT_TRIG, CNV, WAIT_BUSY, SHIFT, ACCUM, DONE, ERR
  } state_t;

  state_t                        state, state_d;
  logic [2:0]                    start_sync, samp_sync, busy_sync;
  logic                          start_rise, samp_rise, busy_fall;
  logic [CNT_W-1:0]              cnt, cnt_d;
  logic [BC_W-1:0]               bc, bc_d;
  logic                          sck_d;
  logic [FRAME_W-1:0]            shreg, shreg_d;
  logic [ACC_WIDTH-1:0]          acc [NUM_CH];
  logic [ACC_WIDTH-1:0]          acc_d [NUM_CH];
  logic [FC_W-1:0]               fcnt, fcnt_d, fc_target;
  logic [3:0]                    log2_q, log2_d;
  logic [NUM_CH*OUT_WIDTH-1:0]   data_d;
  logic                          overrun_d;

  function automatic logic [ACC_WIDTH-1:0] extend(input logic [CH_WIDTH-1:0] s);
`ifdef ADC_MULTI_AVG_SIGNED_EN
    return ACC_WIDTH'($signed(s));
`else
    return ACC_WIDTH'(s);
`endif
  endfunction

  function automatic logic [OUT_WIDTH-1:0] average(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [3:0] sh);
`ifdef ADC_MULTI_AVG_SIGNED_EN
    return OUT_WIDTH'($signed(a) >>> sh);
`else
    return OUT_WIDTH'(a >> sh);
`endif
  endfunction

  // Edges come from the last two synchronised samples (bit 1 = synced, bit 2 = edge register)
  assign start_rise = start_sync[1] & ~start_sync[2];
  assign samp_rise  = samp_sync[1]  & ~samp_sync[2];
  assign busy_fall  = ~busy_sync[1] &  busy_sync[2];
  assign fc_target  = FC_W'(1) << log2_q;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bc_d      = bc;
    sck_d     = sck;
    shreg_d   = shreg;
    acc_d     = acc;
    fcnt_d    = fcnt;
    log2_d    = log2_q;
    data_d    = data_out;
    overrun_d = overrun;

    if (samp_rise && active && (state != WAIT_TRIG)) overrun_d = 1'b1;

    case (state)
      IDLE: begin
        if (start_rise) begin
          log2_d    = (log2_n > 4'(MAX_LOG2_N)) ? 4'(MAX_LOG2_N) : log2_n;
          for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
          fcnt_d    = '0;
          overrun_d = 1'b0;
          state_d   = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (samp_rise) begin
          cnt_d   = '0;
          state_d = CNV;
        end
      end
      CNV: begin
        if (cnt == CNT_W'(CNV_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_BUSY: begin
        // A fall coinciding with the last timeout cycle wins
        if (busy_fall) begin
          cnt_d   = '0;
          bc_d    = '0;
          sck_d   = 1'b0;
          state_d = SHIFT;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (bc == BC_W'(FRAME_W)) begin
          state_d = ACCUM;
        end else if (cnt == CNT_W'(SCK_DIV - 1)) begin
          cnt_d = '0;
          if (!sck) begin
            sck_d   = 1'b1;
            shreg_d = {shreg[FRAME_W-2:0], miso};
          end else begin
            sck_d = 1'b0;
            bc_d  = bc + BC_W'(1);
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ACCUM: begin
        for (int k = 0; k < NUM_CH; k++)
          acc_d[k] = acc[k] + extend(shreg[(NUM_CH-1-k)*CH_WIDTH +: CH_WIDTH]);
        fcnt_d = fcnt + FC_W'(1);
        if (fcnt_d == fc_target) begin
          for (int k = 0; k < NUM_CH; k++)
            data_d[k*OUT_WIDTH +: OUT_WIDTH] = average(acc_d[k], log2_q);
          state_d = DONE;
        end else begin
          state_d = WAIT_TRIG;
        end
      end
      DONE: state_d = IDLE;
      ERR: begin
        for (int k = 0; k < NUM_CH; k++) acc_d[k] = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync <= '0;
      samp_sync  <= '0;
      busy_sync  <= '0;
      state      <= IDLE;
      cnt        <= '0;
      bc         <= '0;
      sck        <= 1'b0;
      shreg      <= '0;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      fcnt       <= '0;
      log2_q     <= '0;
      data_out   <= '0;
      cnv        <= 1'b0;
      complete   <= 1'b0;
      error      <= 1'b0;
      overrun    <= 1'b0;
      active     <= 1'b0;
    end else begin
      start_sync <= {start_sync[1:0], start_cycle};
      samp_sync  <= {samp_sync[1:0], sample_adc};
      busy_sync  <= {busy_sync[1:0], adc_busy};
      state      <= state_d;
      cnt        <= cnt_d;
      bc         <= bc_d;
      sck        <= sck_d;
      shreg      <= shreg_d;
      acc        <= acc_d;
      fcnt       <= fcnt_d;
      log2_q     <= log2_d;
      data_out   <= data_d;
      cnv        <= (state_d == CNV);
      complete   <= (state_d == DONE);
      error      <= (state_d == ERR);
      overrun    <= overrun_d;
      active     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_adc_multi_avg.sv
// Scoreboard bench for adc_multi_avg with a behavioural ADC (CNV/BUSY/SPI) and an averaging reference.
module tb_adc_multi_avg;
  localparam int unsigned FW = 36;

  logic        clk = 1'b0, rst = 1'b0;
  logic        start_cycle = 1'b0, sample_adc = 1'b0, adc_busy = 1'b0, miso = 1'b0;
  logic [3:0]  log2_n = '0;
  logic        cnv, sck, complete, error, overrun, active;
  logic [47:0] data_out;

  typedef struct { bit is_err; logic [47:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [35:0] adc_q[$];
  logic [35:0] stim_q[$];
  logic [47:0] last_exp = '0;
  int          checks = 0, errors = 0;
  int          cyc = 0, last_sck_fall = 0, last_cnv_fall = 0;
  bit          prev_sck = 0, prev_cnv = 0, prev_strobe = 0, busy_stuck = 0;
  logic [35:0] cur_frame = '0;
  int          bitix = 0;

  adc_multi_avg dut (
    .clk(clk), .rst(rst), .start_cycle(start_cycle), .sample_adc(sample_adc),
    .log2_n(log2_n), .cnv(cnv), .adc_busy(adc_busy), .sck(sck), .miso(miso),
    .data_out(data_out), .complete(complete), .error(error), .overrun(overrun),
    .active(active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic longint sval(input logic [17:0] s);
`ifdef ADC_MULTI_AVG_SIGNED_EN
    return longint'($signed(s));
`else
    return longint'(s);
`endif
  endfunction

  // ADC model: BUSY rises with CNV, falls 10 cycles after CNV falls; frame MSB first, next bit on SCK fall
  initial forever begin
    @(posedge cnv);
    adc_busy = 1'b1;
    @(negedge cnv);
    if (!busy_stuck) begin
      repeat (10) @(negedge clk);
      cur_frame = (adc_q.size() > 0) ? adc_q.pop_front() : 36'h0;
      bitix     = FW - 1;
      miso      = cur_frame[bitix];
      adc_busy  = 1'b0;
    end
  end

  always @(negedge sck) begin
    if (bitix > 0) begin
      bitix--;
      miso = cur_frame[bitix];
    end
  end

  // Monitor: pops the scoreboard on each strobe and checks strobe timing
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_sck = 0; prev_cnv = 0; prev_strobe = 0;
    end else begin
      if (prev_sck && !sck) last_sck_fall = cyc;
      if (prev_cnv && !cnv) last_cnv_fall = cyc;
      if (prev_strobe) chk("active_drop_after_strobe", active, 0);
      if (complete || error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {complete, error}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind_is_error", error, e.is_err);
          chk("data_out_ch0", data_out[23:0], e.data[23:0]);
          chk("data_out_ch1", data_out[47:24], e.data[47:24]);
          if (complete) chk("complete_after_last_sck_fall", cyc - last_sck_fall, 2);
          if (error)    chk("error_after_cnv_fall", cyc - last_cnv_fall, 255);
        end
      end
      prev_sck    = sck;
      prev_cnv    = cnv;
      prev_strobe = complete | error;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_cycle = 1'b1; tick(4);
    start_cycle = 1'b0; tick(4);
  endtask

  task automatic trigger();
    sample_adc = 1'b1; tick(4);
    sample_adc = 1'b0; tick(4);
  endtask

  task automatic wait_sck_high();
    for (int i = 0; i < 100 && !sck; i++) tick(1);
    chk("sck_rise_seen", sck, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && active; i++) tick(1);
    chk("cycle_ends", active, 0);
  endtask

  // Reference: per-channel floor(sum / 2^n), taken modulo the 24-bit result width
  task automatic run_cycle(input int n, input bit inject);
    longint      sum0, sum1;
    int          nf;
    logic [35:0] f;
    logic [47:0] e;
    sum0 = 0; sum1 = 0;
    nf = 1 << n;
    for (int i = 0; i < nf; i++) begin
      f = stim_q.pop_front();
      sum0 += sval(f[35:18]);
      sum1 += sval(f[17:0]);
      adc_q.push_back(f);
    end
    e = {24'(sum1 >>> n), 24'(sum0 >>> n)};
    exp_q.push_back('{1'b0, e});
    last_exp = e;
    log2_n = 4'(n);
    pulse_start();
    chk("active_after_start", active, 1);
    chk("overrun_clear_at_start", overrun, 0);
    for (int i = 0; i < nf; i++) begin
      trigger();
      if (inject && i == 0) begin
        wait_sck_high();
        trigger();
      end
      tick(200);
    end
    wait_idle();
  endtask

  task automatic push_frame(input logic [17:0] c0, input logic [17:0] c1);
    stim_q.push_back({c0, c1});
  endtask

  initial begin
    #1;
    chk("reset_cnv", cnv, 0);
    chk("reset_sck", sck, 0);
    chk("reset_complete", complete, 0);
    chk("reset_error", error, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_active", active, 0);
    chk("reset_data_out", data_out, 0);
    tick(3);
    rst = 1'b1;
    tick(4);

    for (int i = 0; i < 4; i++) push_frame(18'h00010, 18'h3FFF0);
    run_cycle(2, 0);

    push_frame(18'd3, 18'h00155);
    push_frame(18'd4, 18'h00155);
    run_cycle(1, 0);

    // BUSY never falls: error strobe, data_out unchanged
    busy_stuck = 1;
    exp_q.push_back('{1'b1, last_exp});
    log2_n = 4'd1;
    pulse_start();
    chk("active_err_cycle", active, 1);
    trigger();
    wait_idle();
    chk("data_out_held_after_error", data_out, last_exp);
    busy_stuck = 0;
    adc_busy   = 1'b0;
    tick(4);

    // Extra trigger during SHIFT sets sticky overrun
    push_frame(18'(($urandom)), 18'(($urandom)));
    push_frame(18'(($urandom)), 18'(($urandom)));
    run_cycle(1, 1);
    chk("overrun_sticky", overrun, 1);
    push_frame(18'h00ABC, 18'h12345);
    run_cycle(0, 0);

    push_frame(18'h3FFFF, 18'h00001);
    push_frame(18'h3FFFD, 18'h00003);
    run_cycle(1, 0);

    // Reset mid-SHIFT
    adc_q.push_back({18'h11111, 18'h22222});
    log2_n = 4'd1;
    pulse_start();
    trigger();
    wait_sck_high();
    rst = 1'b0;
    #1;
    chk("midreset_sck", sck, 0);
    chk("midreset_cnv", cnv, 0);
    chk("midreset_active", active, 0);
    chk("midreset_data_out", data_out, 0);
    tick(3);
    rst = 1'b1;
    last_exp = '0;
    adc_q.delete();
    tick(4);
    push_frame(18'h01234, 18'h3ABCD);
    push_frame(18'h00FFF, 18'h20000);
    run_cycle(1, 0);

    for (int r = 0; r < 3; r++) begin
      int n;
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < (1 << n); i++) push_frame(18'($urandom), 18'($urandom));
      run_cycle(n, 0);
    end

    tick(5);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_multi_avg.md
# adc_multi_avg

Parametrised successor of the dual-channel averaging ADC reader. It triggers a daisy-chained multi-channel ADC (CNV/BUSY handshake), shifts out one frame per trigger over a built-in SPI receiver and accumulates 2^log2_n frames per channel. It then publishes per-channel averages with a one-cycle `complete` strobe. It sits between the sample-rate timer (`sample_adc`), the measurement sequencer (`start_cycle`) and the result registers.

## Interface
- `NUM_CH`, 2, number of channels in one ADC frame.
- `CH_WIDTH`, 18, bits per channel sample.
- `OUT_WIDTH`, 24, bits per channel result; must be ≥ CH_WIDTH.
- `MAX_LOG2_N`, 10, largest accepted `log2_n`.
- `ACC_WIDTH`, 28, accumulator width; must be ≥ CH_WIDTH+MAX_LOG2_N.
- `SCK_DIV`, 2, clk cycles per SCK half-period (≥1).
- `CNV_CYCLES`, 2, width of the `cnv` pulse in clk cycles.
- `BUSY_TIMEOUT`, 255, clk cycles allowed for BUSY to fall.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `start_cycle` in 1: async; its rising edge starts an averaging cycle.
- `sample_adc` in 1: async; its rising edge triggers one conversion.
- `log2_n` in 4: averaging depth, latched at cycle start; clamped to MAX_LOG2_N.
- `cnv` out 1: ADC convert pulse.
- `adc_busy` in 1: async; a falling edge means the conversion is done.
- `sck` out 1: SPI clock.
- `miso` in 1: SPI data.
- `data_out` out NUM_CH*OUT_WIDTH: channel k occupies bits [k*OUT_WIDTH +: OUT_WIDTH].
- `complete` out 1: one-cycle strobe when `data_out` updates.
- `error` out 1: one-cycle strobe on a BUSY timeout.
- `overrun` out 1: sticky flag for a trigger missed during a cycle.
- `active` out 1: high from cycle start until DONE/ERR.

## Operation
- Synchronise `start_cycle`, `sample_adc` and `adc_busy` through 2 flops each. Detect edges from the last two synchronised samples.
- The FSM has these states: IDLE, WAIT_TRIG, CNV, WAIT_BUSY, SHIFT, ACCUM, DONE, ERR.
- IDLE:
  - On a `start_cycle` rise: latch `log2_n` (clamped), clear the accumulators, the frame counter and `overrun`; go to WAIT_TRIG.
  - `sample_adc` edges in IDLE are ignored.
- WAIT_TRIG: on a `sample_adc` rise, go to CNV.
- CNV: drive `cnv`=1 for CNV_CYCLES, then go to WAIT_BUSY with the timeout counter cleared.
- WAIT_BUSY:
  - On a `adc_busy` fall, go to SHIFT.
  - If the counter reaches BUSY_TIMEOUT first, go to ERR.
- SHIFT:
  - Shift NUM_CH*CH_WIDTH bits, MSB first. Channel 0 comes first (top of the frame).
  - SCK idles low. `miso` is sampled on SCK rising edges; SCK falls after the last bit.
- ACCUM: add each channel sample, zero-extended to ACC_WIDTH, to its accumulator. Increment the frame counter.
  - If the count equals 2^log2_n, go to DONE.
  - Otherwise go to WAIT_TRIG.
- DONE: `data_out[k]` = acc[k] >> log2_n, extended to OUT_WIDTH. Pulse `complete`, then go to IDLE.
- ERR: pulse `error`, discard the accumulators and leave `data_out` unchanged; go to IDLE.
- A `sample_adc` rise while `active` and not in WAIT_TRIG sets `overrun`. That trigger is dropped.
- A `start_cycle` rise while `active` is ignored.
- With `log2_n`=0, one frame is passed through unchanged.

## Timing
- Reset values: `cnv`=0, `sck`=0, `complete`=0, `error`=0, `overrun`=0, `active`=0, `data_out`=0. The FSM resets to IDLE.
- A reset mid-cycle aborts immediately with no strobe.
- Input edge to FSM reaction: 3 clk cycles (2 sync + 1 edge register).
- Frame shift time: 2*SCK_DIV*NUM_CH*CH_WIDTH clk cycles (144 at defaults).
- The last SCK falls, then ACCUM follows 1 cycle later.
- On the final frame, `complete` is asserted 2 cycles after the last SCK fall. `data_out` is valid in the same cycle and holds until the next `complete`.
- `active` drops in the cycle after the `complete` or `error` strobe.
- `cnv` is deasserted before WAIT_BUSY starts counting. A BUSY fall seen in the same cycle the timeout expires counts as success.
- Accumulators never overflow, given the ACC_WIDTH rule.

## Configuration
- `ADC_MULTI_AVG_SIGNED_EN` defined:
  - Samples are two's complement and are sign-extended into the accumulators.
  - The shift is arithmetic.
  - Results are sign-extended to OUT_WIDTH.
- Not defined: all samples and results are unsigned and zero-extended.

## Test plan
- Defaults, `log2_n`=2, ADC model returns frames ch0=0x00010, ch1=0x3FFF0 four times. Required: one `complete`, ch0=0x000010, ch1=0x03FFF0, `error`=0.
- `log2_n`=1, ch0 samples 3 then 4. Required: ch0=3 (truncating average), ch1 as driven.
- The BUSY model never falls. Required: `error` strobe 255 cycles after `cnv` falls; `data_out` keeps its prior value; FSM back in IDLE.
- A `sample_adc` rise injected during SHIFT. Required: `overrun`=1, frame count unaffected, cycle completes normally. `overrun` clears at the next `start_cycle`.
- `rst` asserted mid-SHIFT. Required: immediately `sck`=0, `cnv`=0, `active`=0, `data_out`=0; a new cycle after release works.
- With `ADC_MULTI_AVG_SIGNED_EN`, `log2_n`=1, ch0 samples 0x3FFFF (−1) and 0x3FFFD (−3). Required: ch0=0xFFFFFE (−2).
